laser_job_sched: RTL and testbench

Job scheduler and sequencer for the two-circle LASER search core. Two requesters each stream a 40-point job into the scheduler, and a round-robin arbiter picks one job at a time. The scheduler buffers the job so the core receives an unbroken 40-cycle burst, restarts the core, waits for its DONE pulse with a timeout, and returns the circle centres tagged with the requester ID. It sits between the requesters' valid/ready streams and one LASER core instance.

---
 rtl/laser_job_sched.sv | 181 ++++++++++++++++++
 tb/tb_laser_job_sched.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_job_sched.sv
// laser_job_sched: round-robin job scheduler and sequencer for one LASER core.
// Buffers a job, kicks and feeds the core, waits for DONE or timeout, returns a tagged result.
// Ports: i_clk, i_rst (sync, active high)
//   i_reqN_valid/o_reqN_ready/i_reqN_x/i_reqN_y : requester point streams (N = 0, 1)
//   o_core_rst/o_core_x/o_core_y, i_core_c1x..c2y/i_core_done : core side
//   o_res_valid/i_res_ready/o_res_id/o_res_timeout/o_res_c1x..c2y : result stream
//   o_busy : high in every state except IDLE
module laser_job_sched #(
    parameter int NPTS    = 40,
    parameter int TIMEOUT = 200000,
    parameter int TO_W    = 18
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [3:0] i_req0_x,
    input  logic [3:0] i_req0_y,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    input  logic [3:0] i_req1_x,
    input  logic [3:0] i_req1_y,
    output logic       o_core_rst,
    output logic [3:0] o_core_x,
    output logic [3:0] o_core_y,
    input  logic [3:0] i_core_c1x,
    input  logic [3:0] i_core_c1y,
    input  logic [3:0] i_core_c2x,
    input  logic [3:0] i_core_c2y,
    input  logic       i_core_done,
    output logic       o_res_valid,
    input  logic       i_res_ready,
    output logic       o_res_id,
    output logic       o_res_timeout,
    output logic [3:0] o_res_c1x,
    output logic [3:0] o_res_c1y,
    output logic [3:0] o_res_c2x,
    output logic [3:0] o_res_c2y,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KICK, S_FEED, S_WAIT, S_RESP
    } state_t;

    localparam logic [5:0]      IDX_LAST = 6'(NPTS - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    state_t          r_state;
    logic [7:0]      r_buf [NPTS];
    logic [5:0]      r_idx;
    logic            r_gnt;
    logic            r_last;
    logic            r_rdy0;
    logic            r_rdy1;
    logic [TO_W-1:0] r_to;
    logic            r_res_valid;
    logic            r_res_id;
    logic            r_res_to;
    logic [3:0]      r_c1x, r_c1y, r_c2x, r_c2y;

    logic       w_hs;
    logic       w_pick;
    logic [3:0] w_x;
    logic [3:0] w_y;

    assign w_hs = r_gnt ? (i_req1_valid & r_rdy1) : (i_req0_valid & r_rdy0);
    assign w_x  = r_gnt ? i_req1_x : i_req0_x;
    assign w_y  = r_gnt ? i_req1_y : i_req0_y;

    // On a tie the requester not granted last wins; otherwise whoever is valid.
    assign w_pick = (i_req0_valid & i_req1_valid) ? ~r_last : i_req1_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_gnt       <= 1'b0;
            r_last      <= 1'b1;
            r_rdy0      <= 1'b0;
            r_rdy1      <= 1'b0;
            r_to        <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_to    <= 1'b0;
            r_c1x       <= '0;
            r_c1y       <= '0;
            r_c2x       <= '0;
            r_c2y       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_req0_valid | i_req1_valid) begin
                        r_gnt   <= w_pick;
                        r_last  <= w_pick;
                        r_idx   <= '0;
                        r_rdy0  <= ~w_pick;
                        r_rdy1  <= w_pick;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_idx <= r_idx + 6'd1;
                        if (r_idx == IDX_LAST) begin
                            r_rdy0  <= 1'b0;
                            r_rdy1  <= 1'b0;
                            r_state <= S_KICK;
                        end
                    end
                end
                S_KICK: begin
                    r_idx   <= '0;
                    r_state <= S_FEED;
                end
                S_FEED: begin
                    if (r_idx == IDX_LAST) begin
                        r_to    <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx <= r_idx + 6'd1;
                    end
                end
                S_WAIT: begin
                    // DONE takes priority over an expiry in the same cycle.
                    if (i_core_done) begin
                        r_c1x       <= i_core_c1x;
                        r_c1y       <= i_core_c1y;
                        r_c2x       <= i_core_c2x;
                        r_c2y       <= i_core_c2y;
                        r_res_to    <= 1'b0;
                        r_res_id    <= r_gnt;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_to == TO_LAST) begin
                        r_c1x       <= '0;
                        r_c1y       <= '0;
                        r_c2x       <= '0;
                        r_c2y       <= '0;
                        r_res_to    <= 1'b1;
                        r_res_id    <= r_gnt;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_to <= r_to + TO_ONE;
                    end
                end
                S_RESP: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Buffer contents need no reset: the index and state gate every use.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD && w_hs) begin
            r_buf[r_idx] <= {w_y, w_x};
        end
    end

    assign o_req0_ready  = r_rdy0;
    assign o_req1_ready  = r_rdy1;
    assign o_core_rst    = i_rst | (r_state == S_KICK);
    assign o_core_x      = (r_state == S_FEED) ? r_buf[r_idx][3:0] : 4'd0;
    assign o_core_y      = (r_state == S_FEED) ? r_buf[r_idx][7:4] : 4'd0;
    assign o_res_valid   = r_res_valid;
    assign o_res_id      = r_res_id;
    assign o_res_timeout = r_res_to;
    assign o_res_c1x     = r_c1x;
    assign o_res_c1y     = r_c1y;
    assign o_res_c2x     = r_c2x;
    assign o_res_c2y     = r_c2y;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_laser_job_sched.sv
// tb_laser_job_sched: randomized self-checking bench for laser_job_sched.
// Drives both requesters, acts as the core, and checks feed, result and timing.
module tb_laser_job_sched;

    localparam int NPTS = 40;
    localparam int TMO  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic       core_rst;
    logic [3:0] core_x, core_y;
    logic [3:0] c1x = '0, c1y = '0, c2x = '0, c2y = '0;
    logic       core_done = 1'b0;
    logic       res_valid, res_id, res_to;
    logic       res_ready = 1'b0;
    logic [3:0] r1x, r1y, r2x, r2y;
    logic       busy;

    laser_job_sched #(.NPTS(NPTS), .TIMEOUT(TMO), .TO_W(18)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
        .i_req0_x(req0_x), .i_req0_y(req0_y),
        .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
        .i_req1_x(req1_x), .i_req1_y(req1_y),
        .o_core_rst(core_rst), .o_core_x(core_x), .o_core_y(core_y),
        .i_core_c1x(c1x), .i_core_c1y(c1y),
        .i_core_c2x(c2x), .i_core_c2y(c2y),
        .i_core_done(core_done),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_id(res_id), .o_res_timeout(res_to),
        .o_res_c1x(r1x), .o_res_c1y(r1y),
        .o_res_c2x(r2x), .o_res_c2y(r2y),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] pts0 [NPTS];
    logic [7:0] pts1 [NPTS];
    int last_hs [2];
    bit m_last = 1'b1;
    int hs_edge = 0;

    int kick_cnt = 0, kick_edge = 0, kick_len = 0;
    int feed_n = 0, feed_cnt = 0, wait_edge = 0, rise_edge = 0;
    bit feeding = 1'b0, prev_crst = 1'b1, prev_rv = 1'b0;
    logic [7:0] feed [NPTS];

    // Observer: sampled 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (core_rst && !rst) begin
            if (!prev_crst) begin
                kick_cnt++;
                kick_edge = cyc;
                kick_len = 1;
                feeding = 1'b1;
                feed_n = 0;
            end else begin
                kick_len++;
            end
        end else if (rst) begin
            feeding = 1'b0;
        end else if (feeding) begin
            feed[feed_n] = {core_y, core_x};
            feed_n++;
            if (feed_n == NPTS) begin
                feeding = 1'b0;
                feed_cnt++;
                wait_edge = cyc + 1;
            end
        end
        if (res_valid && !prev_rv) rise_edge = cyc;
        prev_crst = core_rst;
        prev_rv = res_valid;
    end

    function automatic bit arb(input bit a, input bit b);
        bit g;
        g = (a && b) ? ~m_last : b;
        m_last = g;
        return g;
    endfunction

    task automatic gen_pts(input bit id);
        for (int k = 0; k < NPTS; k++) begin
            if (id) pts1[k] = 8'($urandom);
            else pts0[k] = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        core_done = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic drive_load(input bit id, input bit stall,
                              output int rdy_cyc, output int first_rdy);
        int k = 0, p = 0, guard = 0;
        bit rdy, v;
        first_rdy = -1;
        while (k < NPTS && guard < 3000) begin
            @(negedge clk);
            guard++;
            rdy = id ? req1_ready : req0_ready;
            if (rdy && first_rdy < 0) first_rdy = cyc;
            v = !(stall && rdy && (p % 3 == 2));
            if (id) begin
                req1_valid = v;
                req1_x = pts1[k][3:0];
                req1_y = pts1[k][7:4];
            end else begin
                req0_valid = v;
                req0_x = pts0[k][3:0];
                req0_y = pts0[k][7:4];
            end
            if (rdy) p++;
            if (rdy && v) begin
                k++;
                last_hs[id] = cyc + 1;
            end
        end
        @(negedge clk);
        if (id) req1_valid = 1'b0;
        else req0_valid = 1'b0;
        rdy_cyc = p;
        checks++;
        if (k != NPTS) begin
            errors++;
            $display("FAIL load_done: req%0d beats %0d, required %0d", id, k, NPTS);
        end
    endtask

    task automatic serve_core(input bit id, input int fc_tgt,
                              input int delay, input logic [15:0] cent);
        int guard = 0, bad = 0, first = 0;
        logic [7:0] e;
        while (feed_cnt < fc_tgt && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (feed_cnt < fc_tgt) begin
            errors++;
            $display("FAIL feed_done: feeds %0d, required %0d", feed_cnt, fc_tgt);
            return;
        end
        checks++;
        if (kick_edge != last_hs[id] || kick_len != 1) begin
            errors++;
            $display("FAIL kick: edge %0d len %0d, required edge %0d len 1",
                     kick_edge, kick_len, last_hs[id]);
        end
        for (int k = NPTS - 1; k >= 0; k--) begin
            e = id ? pts1[k] : pts0[k];
            if (feed[k] !== e) begin
                bad++;
                first = k;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            e = id ? pts1[first] : pts0[first];
            $display("FAIL feed_order: %0d bad, idx %0d got %h, required %h",
                     bad, first, feed[first], e);
        end
        if (delay >= 0) begin
            repeat (delay) @(negedge clk);
            {c1x, c1y, c2x, c2y} = cent;
            core_done = 1'b1;
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL res_early: res_valid %b, required 0", res_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if (res_valid !== 1'b1) begin
                errors++;
                $display("FAIL res_latency: res_valid %b, required 1", res_valid);
            end
            @(negedge clk);
            core_done = 1'b0;
            {c1x, c1y, c2x, c2y} = 16'($urandom);
        end else begin
            guard = 0;
            while (!res_valid && guard < TMO + 100) begin
                @(negedge clk);
                guard++;
            end
            checks++;
            if (rise_edge - wait_edge != TMO) begin
                errors++;
                $display("FAIL timeout_latency: %0d cycles, required %0d",
                         rise_edge - wait_edge, TMO);
            end
        end
    endtask

    task automatic check_result(input logic [17:0] exp, input int hold);
        int guard = 0;
        bit bad = 1'b0;
        logic [17:0] got;
        while (!res_valid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        got = {res_id, res_to, r1x, r1y, r2x, r2y};
        checks++;
        if (res_valid !== 1'b1 || got !== exp) begin
            errors++;
            $display("FAIL result: valid %b got %h, required valid 1 %h",
                     res_valid, got, exp);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if ({res_id, res_to, r1x, r1y, r2x, r2y} !== got ||
                    res_valid !== 1'b1 || busy !== 1'b1 ||
                    req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL hold_stable: changed during backpressure, required stable");
            end
        end
        res_ready = 1'b1;
        hs_edge = cyc + 1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL res_clear: valid %b busy %b, required 0 0", res_valid, busy);
        end
    endtask

    task automatic test_reset();
        int p, f;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_core: core_rst %b busy %b, required 1 0", core_rst, busy);
        end
        checks++;
        if ({req0_ready, req1_ready, res_valid, res_id, res_to} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: %b, required 00000",
                     {req0_ready, req1_ready, res_valid, res_id, res_to});
        end
        checks++;
        if ({r1x, r1y, r2x, r2y, core_x, core_y} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data: %h, required 0",
                     {r1x, r1y, r2x, r2y, core_x, core_y});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: core_rst %b, required 0", core_rst);
        end
    endtask

    task automatic test_single();
        int p, f, fc0;
        bit id;
        do_reset();
        for (int k = 0; k < NPTS; k++) pts0[k] = (k % 5 == 3) ? 8'hCC : 8'h55;
        fc0 = feed_cnt;
        id = arb(1'b1, 1'b0);
        drive_load(1'b0, 1'b0, p, f);
        checks++;
        if (p != NPTS || req0_ready !== 1'b0 || core_rst !== 1'b1) begin
            errors++;
            $display("FAIL single_load: cycles %0d ready %b core_rst %b, required %0d 0 1",
                     p, req0_ready, core_rst, NPTS);
        end
        serve_core(1'b0, fc0 + 1, $urandom_range(1, 20), 16'h55CC);
        check_result({id, 1'b0, 16'h55CC}, 0);
    endtask

    task automatic test_contention();
        int p0, p1, f0, f1, fc0;
        bit ida, idb, done0, bad1;
        logic [15:0] ca, cb;
        gen_pts(1'b0);
        gen_pts(1'b1);
        ca = 16'($urandom);
        cb = 16'($urandom);
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1;
        {req0_y, req0_x} = pts0[0];
        req1_valid = 1'b1;
        {req1_y, req1_x} = pts1[0];
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_last = 1'b1;
        ida = arb(1'b1, 1'b1);
        idb = arb(1'b0, 1'b1);
        fc0 = feed_cnt;
        done0 = 1'b0;
        bad1 = 1'b0;
        fork
            drive_load(1'b0, 1'b0, p0, f0);
            drive_load(1'b1, 1'b0, p1, f1);
            begin
                serve_core(ida, fc0 + 1, $urandom_range(1, 20), ca);
                check_result({ida, 1'b0, ca}, 0);
                done0 = 1'b1;
                serve_core(idb, fc0 + 2, $urandom_range(1, 20), cb);
                check_result({idb, 1'b0, cb}, 0);
            end
            begin
                for (int g = 0; g < 2000 && !done0; g++) begin
                    @(negedge clk);
                    if (!done0 && req1_ready) bad1 = 1'b1;
                end
            end
        join
        checks++;
        if (bad1) begin
            errors++;
            $display("FAIL contention_lockout: req1_ready 1 during req0 job, required 0");
        end
    endtask

    task automatic test_stalls();
        int p, f, fc0;
        bit id;
        logic [15:0] c;
        do_reset();
        gen_pts(1'b1);
        c = 16'($urandom);
        fc0 = feed_cnt;
        id = arb(1'b0, 1'b1);
        drive_load(1'b1, 1'b1, p, f);
        checks++;
        if (p != 59) begin
            errors++;
            $display("FAIL stall_load_len: %0d cycles, required 59", p);
        end
        serve_core(1'b1, fc0 + 1, $urandom_range(1, 20), c);
        check_result({id, 1'b0, c}, 0);
    endtask

    task automatic test_timeout();
        int p, f, fc0, kc0;
        bit id;
        logic [15:0] c;
        do_reset();
        gen_pts(1'b0);
        fc0 = feed_cnt;
        id = arb(1'b1, 1'b0);
        drive_load(1'b0, 1'b0, p, f);
        serve_core(1'b0, fc0 + 1, -1, 16'h0);
        @(negedge clk);
        {c1x, c1y, c2x, c2y} = 16'hFFFF;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check_result({id, 1'b1, 16'h0}, 3);
        gen_pts(1'b1);
        c = 16'($urandom);
        kc0 = kick_cnt;
        id = arb(1'b0, 1'b1);
        drive_load(1'b1, 1'b0, p, f);
        serve_core(1'b1, fc0 + 2, $urandom_range(1, 20), c);
        checks++;
        if (kick_cnt != kc0 + 1) begin
            errors++;
            $display("FAIL fresh_kick: kicks %0d, required %0d", kick_cnt, kc0 + 1);
        end
        check_result({id, 1'b0, c}, 0);
    endtask

    task automatic test_backpressure();
        int p, f, fc0;
        bit id;
        logic [15:0] c;
        do_reset();
        gen_pts(1'b0);
        gen_pts(1'b1);
        c = 16'($urandom);
        fc0 = feed_cnt;
        id = arb(1'b1, 1'b0);
        drive_load(1'b0, 1'b0, p, f);
        serve_core(1'b0, fc0 + 1, $urandom_range(1, 20), c);
        req1_valid = 1'b1;
        {req1_y, req1_x} = pts1[0];
        check_result({id, 1'b0, c}, 50);
        id = arb(1'b0, 1'b1);
        c = 16'($urandom);
        drive_load(1'b1, 1'b0, p, f);
        checks++;
        if (f != hs_edge + 1) begin
            errors++;
            $display("FAIL regrant: ready at edge %0d, required %0d", f, hs_edge + 1);
        end
        serve_core(1'b1, fc0 + 2, $urandom_range(1, 20), c);
        check_result({id, 1'b0, c}, 0);
    endtask

    task automatic test_reset_mid_feed();
        int p, f, fc0, guard;
        bit id;
        logic [15:0] c;
        do_reset();
        gen_pts(1'b0);
        void'(arb(1'b1, 1'b0));
        drive_load(1'b0, 1'b0, p, f);
        guard = 0;
        while (!(feeding && feed_n == 21) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || core_rst !== 1'b1 ||
            {req0_ready, req1_ready, core_x, core_y} !== 10'b0) begin
            errors++;
            $display("FAIL mid_reset: busy %b res_valid %b core_rst %b, required 0 0 1",
                     busy, res_valid, core_rst);
        end
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_core: core_rst %b, required 1", core_rst);
        end
        rst = 1'b0;
        m_last = 1'b1;
        gen_pts(1'b0);
        c = 16'($urandom);
        fc0 = feed_cnt;
        id = arb(1'b1, 1'b0);
        drive_load(1'b0, 1'b0, p, f);
        serve_core(1'b0, fc0 + 1, $urandom_range(1, 20), c);
        check_result({id, 1'b0, c}, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stalls();
        test_timeout();
        test_backpressure();
        test_reset_mid_feed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
